// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared FSM state type and active-low 7-segment codes {dp,g,f,e,d,c,b,a}.
package bcd_disp_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] BLANK = 8'hFF;
  function automatic logic [7:0] seg7(input logic [3:0] bcd);
    case (bcd)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return BLANK;
    endcase
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD digit cell with load, ripple carry (up) or borrow (down).
module bcd_digit (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  input  logic       cin_i,
  output logic [3:0] q_o,
  output logic       cout_o
);
  logic [3:0] q_q, q_d;
  assign cout_o = cin_i & (dec_i ? q_q == 4'd0 : q_q == 4'd9);
  assign q_d = load_i ? load_val_i : !cin_i ? q_q :
               dec_i ? (q_q == 4'd0 ? 4'd9 : q_q - 4'd1) : (q_q == 4'd9 ? 4'd0 : q_q + 4'd1);
  assign q_o = q_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) q_q <= '0;
    else q_q <= q_d;
endmodule

// File: rtl/bcd_stop_counter_n.sv
// bcd_stop_counter_n: N-digit BCD up/down stop counter with multiplexed active-low 7-seg display.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits above digit 0.
module bcd_stop_counter_n
  import bcd_disp_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int TICK_DIV = 100_000_000,
  parameter int SCAN_DIV = 262_144,
  parameter int STOP_W   = 10
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Pause,
  input  logic                  Dir,
  input  logic [STOP_W-1:0]     Stop,
  output logic                  Done,
  output logic [4*DIGITS-1:0]   Count_Bcd,
  output logic [7:0]            Anode,
  output logic [7:0]            Display
);
  localparam int MAXV = 10 ** DIGITS - 1;
  localparam int BW   = $clog2(MAXV + 1);
  localparam int TW   = STOP_W > BW ? STOP_W : BW;
  localparam int TDW  = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int SDW  = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;

  state_t         state_q;
  logic           dir_q;
  logic [BW-1:0]  tgt, tgt_q, bin_q, bin_nx, end_v;
  logic [TDW-1:0] tick_q;
  logic [SDW-1:0] scan_q;
  logic [2:0]     idx_q;
  logic [7:0]     anode_q, disp_q, anode_d, disp_d;
  logic           tick, scan_wrap, at_end, step, carry_unused;
  logic [DIGITS:0] c;
  logic [3:0]     dig [8];

  assign tgt       = (TW'(Stop) > TW'(MAXV)) ? BW'(MAXV) : BW'(Stop);
  assign end_v     = dir_q ? '0 : tgt_q;
  assign bin_nx    = dir_q ? bin_q - 1'b1 : bin_q + 1'b1;
  assign tick      = tick_q == TDW'(TICK_DIV - 1);
  assign scan_wrap = scan_q == SDW'(SCAN_DIV - 1);
  assign at_end    = bin_q == end_v;
  assign step      = !Start && state_q == RUN && !at_end && !Pause && tick;
  assign c[0]         = step;
  assign carry_unused = c[DIGITS];

  // The binary shadow count decides termination; the BCD chain only mirrors it.
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    logic [3:0] ld;
    assign ld = Dir ? 4'((tgt / BW'(10 ** i)) % BW'(10)) : 4'd0;
    bcd_digit u_digit (
      .clk_i      (Clk),
      .rst_ni     (Reset),
      .load_i     (Start),
      .load_val_i (ld),
      .dec_i      (dir_q),
      .cin_i      (c[i]),
      .q_o        (Count_Bcd[4*i +: 4]),
      .cout_o     (c[i+1])
    );
  end

  for (genvar k = 0; k < 8; k++) begin : g_pad
    if (k < DIGITS) begin : g_on
      assign dig[k] = Count_Bcd[4*k +: 4];
    end else begin : g_off
      assign dig[k] = 4'd0;
    end
  end

  assign anode_d = ~(8'h01 << idx_q);
`ifdef LEADING_ZERO_BLANK_EN
  logic hi_zero;
  always_comb begin
    hi_zero = idx_q != 3'd0;
    for (int k = 0; k < 8; k++) if (k >= int'(idx_q) && dig[k] != 4'd0) hi_zero = 1'b0;
  end
  assign disp_d = hi_zero ? BLANK : seg7(dig[idx_q]);
`else
  assign disp_d = seg7(dig[idx_q]);
`endif

  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      tgt_q   <= '0;
      bin_q   <= '0;
      tick_q  <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
      anode_q <= 8'hFF;
      disp_q  <= 8'hFF;
    end else begin
      tick_q  <= (Start || tick) ? '0 : tick_q + 1'b1;
      scan_q  <= scan_wrap ? '0 : scan_q + 1'b1;
      idx_q   <= !scan_wrap ? idx_q : idx_q == 3'(DIGITS - 1) ? 3'd0 : idx_q + 3'd1;
      anode_q <= anode_d;
      disp_q  <= disp_d;
      if (step) bin_q <= bin_nx;
      if (Start) begin
        state_q <= RUN;
        dir_q   <= Dir;
        tgt_q   <= tgt;
        bin_q   <= Dir ? tgt : '0;
      end else if (state_q == RUN)
        state_q <= (at_end || (step && bin_nx == end_v)) ? DONE : Pause ? PAUSED : RUN;
      else if (state_q == PAUSED && !Pause)
        state_q <= RUN;
    end

  assign Done    = state_q == DONE;
  assign Anode   = anode_q;
  assign Display = disp_q;
endmodule

// File: tb/tb_bcd_stop_counter_n.sv
// tb_bcd_stop_counter_n: random + directed stimulus against an integer-level stopwatch model.
module tb_bcd_stop_counter_n;
  localparam int ND = 3, TD = 4, SD = 2;
  localparam int MAXV = 10 ** ND - 1;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
  localparam logic [7:0] SEG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic Clk = 1'b0, Reset = 1'b1, Start = 1'b0, Pause = 1'b0, Dir = 1'b0;
  logic [9:0] Stop = '0;
  logic Done;
  logic [4*ND-1:0] Count_Bcd;
  logic [7:0] Anode, Display;

  bcd_stop_counter_n #(.DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD), .STOP_W(10)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Pause(Pause), .Dir(Dir), .Stop(Stop),
    .Done(Done), .Count_Bcd(Count_Bcd), .Anode(Anode), .Display(Display)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0, n_pass = 0;
  int m_cnt, m_tgt, m_dir, m_mode, m_ph, m_sc, m_idx;
  logic [7:0] e_an, e_ds;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int to_bcd(input int v);
    int r = 0;
    for (int i = 0; i < ND; i++) r += ((v / (10 ** i)) % 10) << (4 * i);
    return r;
  endfunction

  function automatic logic [7:0] shown(input int v, input int i);
    int d;
    d = (v / (10 ** i)) % 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && v / (10 ** i) == 0) return 8'hFF;
`endif
    return SEG[d];
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_tgt = 0; m_dir = 0; m_mode = M_IDLE;
    m_ph = 0; m_sc = 0; m_idx = 0; e_an = 8'hFF; e_ds = 8'hFF;
  endtask

  task automatic model_edge();
    int endv;
    bit tk;
    e_an = 8'hFF ^ (8'h01 << m_idx);
    e_ds = shown(m_cnt, m_idx);
    m_sc++;
    if (m_sc == SD) begin m_sc = 0; m_idx = (m_idx + 1) % ND; end
    tk = (m_ph == TD - 1);
    m_ph = Start ? 0 : (m_ph + 1) % TD;
    if (Start) begin
      m_tgt = int'(Stop) > MAXV ? MAXV : int'(Stop);
      m_dir = int'(Dir);
      m_cnt = Dir ? m_tgt : 0;
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      endv = m_dir ? 0 : m_tgt;
      if (m_cnt == endv) m_mode = M_DONE;
      else if (Pause) m_mode = M_PAUSED;
      else if (tk) begin
        m_cnt += m_dir ? -1 : 1;
        if (m_cnt == endv) m_mode = M_DONE;
      end
    end else if (m_mode == M_PAUSED && !Pause) m_mode = M_RUN;
  endtask

  task automatic cyc();
    @(posedge Clk);
    if (Reset) model_edge(); else model_reset();
    @(negedge Clk);
    check("count", Count_Bcd, to_bcd(m_cnt));
    check("done", Done, m_mode == M_DONE);
    check("anode", Anode, e_an);
    check("display", Display, e_ds);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic pulse_start(input int stop, input bit dir);
    Start = 1'b1; Stop = 10'(stop); Dir = dir;
    cyc();
    Start = 1'b0; Stop = 10'($urandom); Dir = 1'($urandom);
  endtask

  task automatic reset_and_scan();
    #2 Reset = 1'b0;
    #1;
    check("rst_anode", Anode, 8'hFF);
    check("rst_display", Display, 8'hFF);
    check("rst_done", Done, 1'b0);
    check("rst_count", Count_Bcd, 12'h000);
    model_reset();
    run(3);
    Reset = 1'b1;
    cyc(); check("scan0", Anode, 8'hFE);
    run(2); check("scan1", Anode, 8'hFD);
    run(2); check("scan2", Anode, 8'hFB);
    run(2); check("scan_wrap", Anode, 8'hFE);
  endtask

  initial begin
    model_reset();
    reset_and_scan();
    // up count to 12
    pulse_start(12, 0);
    run(47);
    check("up_pre", Count_Bcd, 12'h011);
    check("up_pre_done", Done, 1'b0);
    cyc();
    check("up_hit", Count_Bcd, 12'h012);
    check("up_done", Done, 1'b1);
    run(80);
    check("up_hold", Count_Bcd, 12'h012);
    // down count with clamp
    pulse_start(1023, 1);
    check("dn_load", Count_Bcd, 12'h999);
    run(40);
    check("dn_989", Count_Bcd, 12'h989);
    run(4 * 889);
    check("dn_100", Count_Bcd, 12'h100);
    run(4);
    check("dn_099", Count_Bcd, 12'h099);
    // pause
    pulse_start(50, 0);
    run(9);
    Pause = 1'b1;
    run(10);
    check("pause_frz", Count_Bcd, 12'h002);
    Pause = 1'b0;
    run(4);
    check("pause_rel", Count_Bcd, 12'h002);
    cyc();
    check("pause_resume", Count_Bcd, 12'h003);
    // zero targets
    pulse_start(0, 0);
    check("zero_run", Done, 1'b0);
    cyc();
    check("zero_done", Done, 1'b1);
    check("zero_cnt", Count_Bcd, 12'h000);
    pulse_start(0, 1);
    cyc();
    check("zero_dn_done", Done, 1'b1);
    // Start coincident with tick and Pause
    pulse_start(400, 0);
    for (int i = 0; i < TD && m_ph != TD - 1; i++) cyc();
    Pause = 1'b1;
    pulse_start(30, 1);
    check("prio_load", Count_Bcd, 12'h030);
    check("prio_done", Done, 1'b0);
    run(12);
    check("prio_paused", Count_Bcd, 12'h030);
    Pause = 1'b0;
    run(9);
    check("prio_resume", Count_Bcd, 12'h028);
    // random traffic
    repeat (1500) begin
      Start = ($urandom % 40) == 0;
      Stop = ($urandom % 2) ? 10'($urandom % 30) : 10'($urandom);
      Dir = 1'($urandom);
      if ($urandom % 25 == 0) Pause = ~Pause;
      cyc();
      Start = 1'b0;
    end
    Pause = 1'b0;
    // asynchronous reset mid-run
    pulse_start(200, 0);
    run(30);
    reset_and_scan();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
